sensor_ctrl: RTL
================

SENSOR_CTRL -- requirements
Module: sensor_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Parameter DEPTH, default 64: number of 32-bit sample words buffered.
REQ-003 Parameter DW, default 32: sample and read-data width.
REQ-004 cpu_clk  in  1  clock; all state updates on the rising edge.
REQ-005 cpu_rstn  in  1  synchronous active-low reset.
REQ-006 sctrl_en  in  1  MMIO enable; sampling is allowed while high.
REQ-007 sctrl_clear  in  1  MMIO clear; empties the buffer and drops the interrupt.
REQ-008 sctrl_addr  in  log2(DEPTH)  word index for CPU read.
REQ-009 sctrl_out  out  DW  read data for sctrl_addr.
REQ-010 sctrl_interrupt  out  1  level interrupt, high while the buffer is full.
REQ-011 sensor_en  out  1  request to the external sensor.
REQ-012 sensor_ready  in  1  single-cycle strobe marking sensor_out valid.
REQ-013 sensor_out  in  DW  sample data; meaningful only when sensor_ready is high.

Function
REQ-014 States SHALL be IDLE, CAPTURE and FULL.
REQ-015 IDLE->CAPTURE when sctrl_en=1 and sctrl_clear=0.
REQ-016 CAPTURE->IDLE when sctrl_en=0; the count is kept, so re-enabling resumes at the same index.
REQ-017 CAPTURE->FULL on the cycle the DEPTH-th sample is written.
REQ-018 FULL->IDLE only on sctrl_clear=1.
REQ-019 Any state->IDLE with count=0 when sctrl_clear=1.
REQ-020 sensor_en SHALL be a combinational output: 1 only in CAPTURE with sctrl_clear=0.
REQ-021 Capture: in any cycle with sensor_en=1 and sensor_ready=1, sensor_out is written to buffer[count] and count increments by 1 at the next edge.
REQ-022 sensor_ready while sensor_en=0 SHALL be ignored; no write and no count change.
REQ-023 X on sensor_out while sensor_ready=0 SHALL never reach the buffer.
REQ-024 count SHALL be log2(DEPTH)+1 bits wide, range 0..DEPTH, and never wrap.
REQ-025 No write SHALL occur in FULL; samples arriving there are dropped.
REQ-026 sctrl_interrupt SHALL be registered and equal 1 exactly while in FULL.
REQ-027 sctrl_interrupt SHALL rise on the edge at which count reaches DEPTH.
REQ-028 If sctrl_clear and a capture coincide, clear wins: no write, count=0, next state IDLE.
REQ-029 Read path SHALL be registered: sctrl_out = buffer[sctrl_addr] one cycle after sctrl_addr is presented.
REQ-030 Reads SHALL be allowed in every state.
REQ-031 Reading an address being written in the same cycle SHALL return the old word.
REQ-032 sctrl_clear SHALL not modify buffer contents; only count and state change.

Reset
REQ-033 On cpu_rstn=0 at a rising edge: state=IDLE, count=0, sctrl_interrupt=0, sctrl_out=0.
REQ-034 While reset is held, sensor_en SHALL be 0.
REQ-035 Buffer contents SHALL not be reset; values before the first write are don't-care.
REQ-036 A reset mid-CAPTURE SHALL abandon the partial buffer; capture restarts at index 0.

Structure
REQ-037 Package sensor_pkg SHALL hold the state enum (IDLE, CAPTURE, FULL), SENSOR_DEPTH=64 and SENSOR_DW=32.
REQ-038 The buffer SHALL be a sub-module sctrl_buffer: DEPTH x DW flops, one write port, one registered read port, no reset on storage.

Verification
REQ-039 Reset, sctrl_en=1, sensor_ready pulse every 4 cycles with data 0x1000+i -> sensor_en=1; after 64 pulses sctrl_interrupt=1 and sensor_en=0 one edge later; reading addr 0..63 gives 0x1000..0x103F, each with 1-cycle latency.
REQ-040 In FULL, drive 3 extra sensor_ready pulses with 0xDEAD -> buffer unchanged, interrupt stays 1.
REQ-041 Assert sctrl_clear for 1 cycle in FULL -> interrupt=0 next edge; recapture from index 0 overwrites word 0 with the new first sample.
REQ-042 Capture 10 samples, drop sctrl_en for 20 cycles while toggling sensor_ready, re-enable -> samples 10.. resume at index 10, nothing written during the pause.
REQ-043 sctrl_clear and sensor_ready in the same cycle with count=5 -> count=0, no write; word 5 keeps its old value.
REQ-044 Drive cpu_rstn=0 for 1 cycle at count=30 -> interrupt=0, sctrl_out=0, sensor_en=0 during reset; next capture writes index 0.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and sizing for the sensor capture controller.
package sensor_pkg;

  localparam int unsigned SENSOR_DEPTH = 64;
  localparam int unsigned SENSOR_DW    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } sensor_state_t;

endpackage

// File: rtl/sctrl_buffer.sv
// Sample storage: DEPTH x DW flops, one write port, one registered read port.
module sctrl_buffer
  import sensor_pkg::*;
#(
  parameter int unsigned DEPTH = SENSOR_DEPTH,
  parameter int unsigned DW    = SENSOR_DW,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read samples the array before this edge's write lands: old word on collision.
  always_ff @(posedge clk) begin
    if (!rstn) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/sensor_ctrl.sv
// Sensor capture controller: fills a sample buffer on sensor strobes and
// raises a level interrupt while the buffer is full.
module sensor_ctrl
  import sensor_pkg::*;
#(
  parameter int unsigned DEPTH = SENSOR_DEPTH,
  parameter int unsigned DW    = SENSOR_DW,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          cpu_clk,
  input  logic          cpu_rstn,
  input  logic          sctrl_en,
  input  logic          sctrl_clear,
  input  logic [AW-1:0] sctrl_addr,
  output logic [DW-1:0] sctrl_out,
  output logic          sctrl_interrupt,
  output logic          sensor_en,
  input  logic          sensor_ready,
  input  logic [DW-1:0] sensor_out
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  sensor_state_t state, state_d;
  logic [CW-1:0] count, count_d;
  logic          cap_wr;

  always_comb begin
    state_d   = state;
    count_d   = count;
    // Gated by reset so the sensor is never requested while reset is held.
    sensor_en = cpu_rstn && (state == CAPTURE) && !sctrl_clear;
    cap_wr    = sensor_en && sensor_ready;
    if (sctrl_clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state)
        IDLE:    if (sctrl_en) state_d = CAPTURE;
        CAPTURE: begin
          if (cap_wr) count_d = count + CW'(1);
          if (cap_wr && (count == LAST)) state_d = FULL;
          else if (!sctrl_en)            state_d = IDLE;
        end
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      state           <= IDLE;
      count           <= '0;
      sctrl_interrupt <= 1'b0;
    end else begin
      state           <= state_d;
      count           <= count_d;
      sctrl_interrupt <= (state_d == FULL);
    end
  end

  sctrl_buffer #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_buffer (
    .clk   (cpu_clk),
    .rstn  (cpu_rstn),
    .we    (cap_wr),
    .waddr (count[AW-1:0]),
    .wdata (sensor_out),
    .raddr (sctrl_addr),
    .rdata (sctrl_out)
  );

endmodule
